md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide controller for the execute stage.
- Accepts a mult or div request from execute-stage decode and latches the operands and destination register tag.
- Runs an internal radix-2 iterative datapath and holds the pipeline stall until the result is ready.
- Returns a one-cycle result pulse with the tag, for writeback into the register file.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- start_mult  in  1  request signed multiply; sampled only in IDLE.
- start_div  in  1  request signed divide; sampled only in IDLE.
- operand_a  in  WIDTH  multiplicand / dividend.
- operand_b  in  WIDTH  multiplier / divisor.
- rd_in  in  5  destination register tag.
- flush  in  1  abort the in-flight operation (branch/jump squash).
- stall  out  1  freeze fetch/decode/execute latches.
- result_valid  out  1  one-cycle pulse; result and result_rd valid.
- result  out  WIDTH  product low word / quotient.
- result_rd  out  5  tag latched at start.
- md_exception  out  1  valid with result_valid; divide-by-zero or multiply overflow.

Behaviour:
- Reset (reset==0 at edge): state IDLE, counter 0. Outputs: stall 0, result_valid 0, result 0, result_rd 0, md_exception 0. Takes effect mid-operation; the aborted operation produces no pulse.
- States:
  - IDLE: on start_mult go to MULT; else on start_div go to DIV or DZ.
  - MULT, DIV: iterate one bit per cycle.
  - DZ: divide-by-zero, one cycle.
  - DONE: one cycle, then IDLE.
- Request priority: start_mult beats start_div when both are high. Starts outside IDLE are ignored.
- At start: latch |a|, |b|, result sign (sign_a XOR sign_b), rd_in. Counter = WIDTH.
- stall:
  - Combinational: (IDLE & (start_mult|start_div) & ~flush) | MULT | DIV | DZ.
  - Deasserted in DONE, so the pipeline advances in the same cycle result_valid is high.
- MULT: shift-add on magnitudes into a 2*WIDTH accumulator; counter decrements each cycle; at 0 go to DONE.
- DIV: restoring division on magnitudes; counter decrements; at 0 go to DONE.
- Latency: start accepted in cycle 0; result_valid in cycle WIDTH+1 (33 by default). DZ: result_valid in cycle 2.
- Result rules:
  - Mult: low WIDTH bits of the signed product.
  - Mult overflow: md_exception=1 when the full signed product does not sign-extend from bit WIDTH-1.
  - Div: quotient truncates toward zero; remainder is discarded.
  - Div by zero: result 0, md_exception=1.
  - MIN_INT / -1: result 0x80000000, md_exception=0.
- Outputs result, result_rd and md_exception hold their values after the pulse until the next DONE.
- flush:
  - In MULT/DIV/DZ: go to IDLE next edge; no result_valid; stall drops combinationally in the same cycle.
  - Coincident with a start in IDLE: the start is ignored.
  - In DONE: the pulse still occurs; the consumer discards it.
- Zero operands: multiply by 0 still takes the full latency (unless MD_EARLY_OUT_EN); 0 / x returns 0.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: MULT goes to DONE as soon as the remaining unshifted multiplier magnitude bits are all zero. Latency becomes (index of highest set bit of |b|)+2; |b|==0 gives latency 1. DIV is unchanged.
- Undefined: fixed WIDTH+1 latency for MULT.

Test Plan:
- Multiply: start_mult, a=7, b=-6 (0xFFFFFFFA), rd_in=5 -> stall high cycles 0-32; cycle 33 result_valid=1, result=0xFFFFFFD6, result_rd=5, md_exception=0.
- Divide: start_div, a=-45, b=7, rd_in=9 -> cycle 33 result=0xFFFFFFFA (-6), result_rd=9, md_exception=0. Also 0x80000000 / -1 -> 0x80000000, md_exception=0.
- Divide by zero and overflow:
  - start_div a=5, b=0 -> cycle 2 result_valid=1, result=0, md_exception=1.
  - start_mult a=0x10000, b=0x10000 -> result=0, md_exception=1.
- Flush and ignored starts:
  - start_mult a=3, b=4, then flush in cycle 10 -> stall low from cycle 10; no result_valid in cycles 10-40.
  - A new start in cycle 12 completes normally at cycle 45.
  - A start_div pulsed in cycle 5 of a running mult is ignored.
- Reset mid-operation: reset=0 in cycle 15 of a divide -> next cycle stall=0, result=0, result_valid=0, result_rd=0; no pulse follows.
- Priority and early-out:
  - start_mult and start_div both high, a=6, b=3 -> result 18.
  - With MD_EARLY_OUT_EN: a=6, b=3 -> result_valid at cycle 3.
  - With MD_EARLY_OUT_EN: b=0 -> result_valid at cycle 1, result 0.

Source files
------------

// File: rtl/md_sequencer.sv
// Iterative radix-2 signed multiply/divide sequencer for the execute stage.
// Build option: define MD_EARLY_OUT_EN to let MULT finish once the remaining multiplier bits are zero.
module md_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd,
  output logic             md_exception
);

`ifdef MD_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_DZ, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               sign_q, sign_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic [4:0]         rdo_q, rdo_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               start_ok;
  logic [2*WIDTH-1:0] mul_acc, prod_s;
  logic               mul_ovf, mul_last, cnt_last;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   quo_n, quo_s;

  // For MULT, opa is the shifting multiplicand and opb the shifting multiplier.
  // For DIV, opa holds the divisor, opb shifts dividend bits out and quotient bits in, acc is the remainder.
  always_comb begin
    abs_a    = operand_a[WIDTH-1] ? -operand_a : operand_a;
    abs_b    = operand_b[WIDTH-1] ? -operand_b : operand_b;
    start_ok = ~flush & (start_mult | start_div);
    cnt_last = (cnt_q == CNT_W'(1));
    mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
    mul_last = cnt_last | (EARLY & (opb_q[WIDTH-1:1] == '0));
    prod_s   = sign_q ? -mul_acc : mul_acc;
    mul_ovf  = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
    rem_sh   = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opa_q[WIDTH-1:0]};
    div_ge   = ~rem_diff[WIDTH];
    quo_n    = {opb_q[WIDTH-2:0], div_ge};
    quo_s    = sign_q ? -quo_n : quo_n;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sign_q  <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sign_q  <= sign_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdo_q   <= rdo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (start_mult)     state_d = (EARLY && abs_b == '0) ? S_DONE : S_MULT;
          else if (start_div) state_d = (operand_b == '0) ? S_DZ : S_DIV;
        end
      end
      S_MULT:  if (flush) state_d = S_IDLE; else if (mul_last) state_d = S_DONE;
      S_DIV:   if (flush) state_d = S_IDLE; else if (cnt_last) state_d = S_DONE;
      S_DZ:    state_d = flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    sign_d = sign_q;
    rd_d   = rd_q;
    res_d  = res_q;
    exc_d  = exc_q;
    rdo_d  = rdo_q;
    case (state_q)
      S_IDLE: begin
        if (state_d != S_IDLE) begin
          acc_d  = '0;
          cnt_d  = CNT_W'(WIDTH);
          sign_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          rd_d   = rd_in;
          if (start_mult) begin
            opa_d = {{WIDTH{1'b0}}, abs_a};
            opb_d = abs_b;
          end else begin
            opa_d = {{WIDTH{1'b0}}, abs_b};
            opb_d = abs_a;
          end
          // Early-out with a zero multiplier skips the datapath entirely.
          if (state_d == S_DONE) begin
            res_d = '0;
            exc_d = 1'b0;
            rdo_d = rd_in;
          end
        end
      end
      S_MULT: begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (state_d == S_DONE) begin
          res_d = prod_s[WIDTH-1:0];
          exc_d = mul_ovf;
          rdo_d = rd_q;
        end
      end
      S_DIV: begin
        acc_d = {{WIDTH{1'b0}}, (div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0])};
        opb_d = quo_n;
        cnt_d = cnt_q - CNT_W'(1);
        if (state_d == S_DONE) begin
          res_d = quo_s;
          exc_d = 1'b0;
          rdo_d = rd_q;
        end
      end
      S_DZ: begin
        if (state_d == S_DONE) begin
          res_d = '0;
          exc_d = 1'b1;
          rdo_d = rd_q;
        end
      end
      default: ;
    endcase
  end

  // stall is released in DONE so writeback and pipeline advance coincide.
  always_comb begin
    stall        = ((state_q == S_IDLE) & start_ok) |
                   (((state_q == S_MULT) | (state_q == S_DIV) | (state_q == S_DZ)) & ~flush);
    result_valid = (state_q == S_DONE);
    result       = res_q;
    result_rd    = rdo_q;
    md_exception = exc_q;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer; cycle 0 is the cycle a start is presented.
module tb_md_sequencer;
  logic        clock, reset, start_mult, start_div, flush;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_in;
  logic        stall, result_valid, md_exception;
  logic [31:0] result;
  logic [4:0]  result_rd;
  int errors = 0;
  int checks = 0;

`ifdef MD_EARLY_OUT_EN
  localparam int LAT_7X6 = 4, LAT_OVF = 18, LAT_PRI = 3, LAT_B0 = 1, LAT_B1 = 2, LAT_IGN = 31;
  localparam logic [31:0] FLUSH_B = 32'h4000_0004;
`else
  localparam int LAT_7X6 = 33, LAT_OVF = 33, LAT_PRI = 33, LAT_B0 = 33, LAT_B1 = 33, LAT_IGN = 33;
  localparam logic [31:0] FLUSH_B = 32'd4;
`endif

  md_sequencer dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in), .flush(flush),
    .stall(stall), .result_valid(result_valid), .result(result),
    .result_rd(result_rd), .md_exception(md_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic s0);
    @(negedge clock);
    start_mult = m; start_div = d; operand_a = a; operand_b = b; rd_in = rd;
    #1 s0 = stall;
  endtask

  task automatic wait_valid(input int max, output int lat, output logic st_ok);
    lat = -1; st_ok = 1'b1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clock);
      start_mult = 0; start_div = 0; flush = 0;
      #1;
      if (result_valid) begin lat = k; break; end
      if (!stall) st_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", result_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_result: got %h want 0", result); end
    checks++; if (result_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", result_rd); end
    checks++; if (md_exception !== 1'b0) begin errors++; $display("FAIL rst_exc: got %b want 0", md_exception); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_mult;
    logic s0, st; int lat;
    issue(1, 0, 32'd7, 32'hFFFF_FFFA, 5'd5, s0);
    wait_valid(60, lat, st);
    checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL mul_stall0: got %b want 1", s0); end
    checks++; if (lat !== LAT_7X6) begin errors++; $display("FAIL mul_lat: got %0d want %0d", lat, LAT_7X6); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mul_stall_hold: got %b want 1", st); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_stall_done: got %b want 0", stall); end
    checks++; if (result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_result: got %h want ffffffd6", result); end
    checks++; if (result_rd !== 5'd5) begin errors++; $display("FAIL mul_rd: got %0d want 5", result_rd); end
    checks++; if (md_exception !== 1'b0) begin errors++; $display("FAIL mul_exc: got %b want 0", md_exception); end
    @(negedge clock); #1;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mul_pulse_len: got %b want 0", result_valid); end
    checks++; if (result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_hold: got %h want ffffffd6", result); end
  endtask

  task automatic test_div;
    logic s0, st; int lat;
    issue(0, 1, 32'hFFFF_FFD3, 32'd7, 5'd9, s0);
    wait_valid(60, lat, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_lat: got %0d want 33", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL div_stall_hold: got %b want 1", st); end
    checks++; if (result !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div_result: got %h want fffffffa", result); end
    checks++; if (result_rd !== 5'd9) begin errors++; $display("FAIL div_rd: got %0d want 9", result_rd); end
    checks++; if (md_exception !== 1'b0) begin errors++; $display("FAIL div_exc: got %b want 0", md_exception); end
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, s0);
    wait_valid(60, lat, st);
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL div_minint: got %h want 80000000", result); end
    checks++; if (md_exception !== 1'b0) begin errors++; $display("FAIL div_minint_exc: got %b want 0", md_exception); end
    issue(0, 1, 32'd0, 32'hFFFF_FFFD, 5'd11, s0);
    wait_valid(60, lat, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_zero_num_lat: got %0d want 33", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL div_zero_num: got %h want 0", result); end
  endtask

  task automatic test_div_zero_overflow;
    logic s0, st; int lat;
    issue(0, 1, 32'd5, 32'd0, 5'd12, s0);
    wait_valid(60, lat, st);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dz_lat: got %0d want 2", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL dz_result: got %h want 0", result); end
    checks++; if (md_exception !== 1'b1) begin errors++; $display("FAIL dz_exc: got %b want 1", md_exception); end
    checks++; if (result_rd !== 5'd12) begin errors++; $display("FAIL dz_rd: got %0d want 12", result_rd); end
    issue(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd13, s0);
    wait_valid(60, lat, st);
    checks++; if (lat !== LAT_OVF) begin errors++; $display("FAIL ovf_lat: got %0d want %0d", lat, LAT_OVF); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL ovf_result: got %h want 0", result); end
    checks++; if (md_exception !== 1'b1) begin errors++; $display("FAIL ovf_exc: got %b want 1", md_exception); end
    issue(1, 0, 32'h8000_0000, 32'd1, 5'd14, s0);
    wait_valid(60, lat, st);
    checks++; if (lat !== LAT_B1) begin errors++; $display("FAIL minx1_lat: got %0d want %0d", lat, LAT_B1); end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL minx1_result: got %h want 80000000", result); end
    checks++; if (md_exception !== 1'b0) begin errors++; $display("FAIL minx1_exc: got %b want 0", md_exception); end
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, s0);
    wait_valid(60, lat, st);
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL minxm1_result: got %h want 80000000", result); end
    checks++; if (md_exception !== 1'b1) begin errors++; $display("FAIL minxm1_exc: got %b want 1", md_exception); end
  endtask

  task automatic test_flush;
    logic s0, bad, busy; int lat; logic st;
    bad = 1'b0;
    issue(1, 0, 32'd3, FLUSH_B, 5'd4, s0);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      start_mult = 0; start_div = 0; flush = (k == 10);
      if (k == 12) begin start_div = 1; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd3; end
      #1;
      if (k == 10) begin checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end end
      if (k == 11) begin checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b want 0", stall); end end
      if (k == 12) begin checks++; if (stall !== 1'b1) begin errors++; $display("FAIL restart_stall: got %b want 1", stall); end end
      if (result_valid && k < 45) bad = 1'b1;
      if (k == 45) begin
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL restart_valid: got %b want 1", result_valid); end
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL restart_result: got %h want 0000000e", result); end
        checks++; if (result_rd !== 5'd3) begin errors++; $display("FAIL restart_rd: got %0d want 3", result_rd); end
      end
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL flush_nopulse: got %b want 0", bad); end
    // Start presented together with flush must be dropped.
    @(negedge clock);
    start_mult = 1; flush = 1; operand_a = 32'd2; operand_b = 32'd2; rd_in = 5'd1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b want 0", stall); end
    busy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock); start_mult = 0; flush = 0; #1;
      if (result_valid || stall) busy = 1'b1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_ignored: got %b want 0", busy); end
    // Flush in DONE does not cancel the pulse.
    issue(0, 1, 32'd5, 32'd0, 5'd6, s0);
    @(negedge clock); start_div = 0; #1;
    @(negedge clock); flush = 1; #1;
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL flush_done_valid: got %b want 1", result_valid); end
    checks++; if (result_rd !== 5'd6) begin errors++; $display("FAIL flush_done_rd: got %0d want 6", result_rd); end
    @(negedge clock); flush = 0; #1;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL flush_done_after: got %b want 0", result_valid); end
    wait_valid(2, lat, st);
  endtask

  task automatic test_ignored_start;
    logic s0, busy; int lat;
    lat = -1;
    issue(1, 0, 32'hFFFF_FFFE, 32'h2000_0000, 5'd7, s0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      start_mult = 0; start_div = 0;
      if (k == 5) begin start_div = 1; operand_a = 32'd1; operand_b = 32'd1; rd_in = 5'd1; end
      #1;
      if (result_valid) begin lat = k; break; end
    end
    checks++; if (lat !== LAT_IGN) begin errors++; $display("FAIL ign_lat: got %0d want %0d", lat, LAT_IGN); end
    checks++; if (result !== 32'hC000_0000) begin errors++; $display("FAIL ign_result: got %h want c0000000", result); end
    checks++; if (result_rd !== 5'd7) begin errors++; $display("FAIL ign_rd: got %0d want 7", result_rd); end
    busy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock); #1;
      if (result_valid || stall) busy = 1'b1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_div: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic s0, bad;
    bad = 1'b0;
    issue(0, 1, 32'hFFFF_FFD3, 32'd7, 5'd9, s0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock); start_div = 0; reset = (k != 15); #1;
    end
    @(negedge clock); reset = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h want 0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", result_valid); end
    checks++; if (result_rd !== 5'd0) begin errors++; $display("FAIL rstmid_rd: got %0d want 0", result_rd); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock); #1;
      if (result_valid) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_nopulse: got %b want 0", bad); end
  endtask

  task automatic test_priority_early;
    logic s0, st; int lat;
    issue(1, 1, 32'd6, 32'd3, 5'd2, s0);
    wait_valid(60, lat, st);
    checks++; if (lat !== LAT_PRI) begin errors++; $display("FAIL pri_lat: got %0d want %0d", lat, LAT_PRI); end
    checks++; if (result !== 32'd18) begin errors++; $display("FAIL pri_result: got %h want 00000012", result); end
    checks++; if (result_rd !== 5'd2) begin errors++; $display("FAIL pri_rd: got %0d want 2", result_rd); end
    issue(1, 0, 32'd5, 32'd0, 5'd8, s0);
    wait_valid(60, lat, st);
    checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL b0_stall0: got %b want 1", s0); end
    checks++; if (lat !== LAT_B0) begin errors++; $display("FAIL b0_lat: got %0d want %0d", lat, LAT_B0); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL b0_result: got %h want 0", result); end
    checks++; if (md_exception !== 1'b0) begin errors++; $display("FAIL b0_exc: got %b want 0", md_exception); end
    checks++; if (result_rd !== 5'd8) begin errors++; $display("FAIL b0_rd: got %0d want 8", result_rd); end
  endtask

  initial begin
    reset = 1'b0; start_mult = 0; start_div = 0; flush = 0;
    operand_a = '0; operand_b = '0; rd_in = '0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero_overflow;
    test_flush;
    test_ignored_start;
    test_reset_mid;
    test_priority_early;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
